// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encodings and timing defaults for key_pulse_gen
// Purpose: FSM state encodings, default 50 MHz timing constants and a width
//          helper shared by the key debounce/strobe logic.
// Ports:   none (package)
package key_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    PRESS_DB = ST_PRESS_DB,
    HELD     = ST_HELD,
    REL_DB   = ST_REL_DB
  } key_state_t;

  localparam int DEF_DB_CYCLES     = 1_000_000;   // 20 ms @ 50 MHz
  localparam int DEF_LONG_CYCLES   = 50_000_000;  // 1 s @ 50 MHz
  localparam int DEF_REPEAT_CYCLES = 10_000_000;  // 200 ms @ 50 MHz

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchronizer with parameterised reset value
// Purpose: brings an asynchronous single-bit input into the clk domain.
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset
//   din    in  1  asynchronous input
//   dout   out 1  synchronized output (two flops deep)
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      dout <= RST_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - debounced key press/release/long/repeat strobe generator
// Purpose: debounces one raw active-low button and emits one-cycle strobes for
//          press, release, long-press and auto-repeat, plus the debounced level.
// Ports:
//   clk            in  1  system clock
//   rst_n          in  1  asynchronous active-low reset
//   key_n          in  1  raw button, active-low, asynchronous
//   key_pulse      out 1  1-cycle strobe on debounced press
//   key_rel_pulse  out 1  1-cycle strobe on debounced release
//   key_level      out 1  debounced pressed level (1 = pressed)
//   key_long       out 1  1-cycle strobe LONG_CYCLES after key_pulse
//   key_rpt        out 1  1-cycle strobe every REPEAT_CYCLES after key_long
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_pulse,
  output logic key_rel_pulse,
  output logic key_level,
  output logic key_long,
  output logic key_rpt
);

  localparam int CW = $clog2(max3(DB_CYCLES, LONG_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  // hold_cnt parks at LONG_CYCLES once key_long has fired; that value doubles
  // as the "long already reported" flag so no extra state bit is needed.
  localparam logic [CW-1:0] LONG_DONE = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);

  logic            ks;
  key_state_t      state;
  logic [CW-1:0]   db_cnt;
  logic [CW-1:0]   hold_cnt;
  logic [CW-1:0]   rpt_cnt;

  // Synchronizer resets to "released" so a key held through reset is seen as
  // a fresh falling edge and gets a full debounce.
  key_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (key_n),
    .dout  (ks)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      rpt_cnt       <= '0;
      key_pulse     <= 1'b0;
      key_rel_pulse <= 1'b0;
      key_level     <= 1'b0;
      key_long      <= 1'b0;
      key_rpt       <= 1'b0;
    end else begin
      key_pulse     <= 1'b0;
      key_rel_pulse <= 1'b0;
      key_long      <= 1'b0;
      key_rpt       <= 1'b0;
      case (state)
        IDLE: begin
          if (!ks) begin
            state  <= PRESS_DB;
            db_cnt <= '0;
          end
        end
        PRESS_DB: begin
          if (ks) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state     <= HELD;
            key_pulse <= 1'b1;
            key_level <= 1'b1;
            hold_cnt  <= '0;
            rpt_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        HELD: begin
          if (ks) begin
            // hold_cnt/rpt_cnt stay frozen while a possible release is judged
            state  <= REL_DB;
            db_cnt <= '0;
          end else if (hold_cnt != LONG_DONE) begin
            if (hold_cnt == LONG_LAST) key_long <= 1'b1;
            hold_cnt <= hold_cnt + CW'(1);
          end else if (REPEAT_EN != 0) begin
            if (rpt_cnt == RPT_LAST) begin
              key_rpt <= 1'b1;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + CW'(1);
            end
          end
        end
        REL_DB: begin
          if (!ks) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            key_rel_pulse <= 1'b1;
            key_level     <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb/tb_key_pulse_gen.sv - scoreboard bench for key_pulse_gen
module tb_key_pulse_gen;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_n = 1'b1;

  logic key_pulse, key_rel_pulse, key_level, key_long, key_rpt;
  logic p2, r2, lvl2, l2, rpt2;

  always #5 clk = ~clk;

  key_pulse_gen #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n         (key_n),
    .key_pulse     (key_pulse),
    .key_rel_pulse (key_rel_pulse),
    .key_level     (key_level),
    .key_long      (key_long),
    .key_rpt       (key_rpt)
  );

  key_pulse_gen #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(0)) dut_norep (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n         (key_n),
    .key_pulse     (p2),
    .key_rel_pulse (r2),
    .key_level     (lvl2),
    .key_long      (l2),
    .key_rpt       (rpt2)
  );

  // event vector bit order: {press, release, long, repeat}
  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic       exp_level = 1'b0;
  logic [3:0] exp_vec = 4'b0;
  bit         done = 1'b0;

  // Reference model: the key is considered to change state once the
  // synchronized sample has disagreed with the debounced level for DB+1
  // consecutive clocks; "held time" counts clocks spent stably pressed.
  logic [1:0] m_sync;
  int         m_run;
  int         m_hold;

  initial begin
    logic ks;
    int   pre_run;
    m_sync = 2'b11; m_run = 0; m_hold = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_sync = 2'b11; m_run = 0; m_hold = 0;
        exp_level = 1'b0; exp_vec = 4'b0;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= cyc) void'(exp_q.pop_back());
        if (clk) cyc++;
      end else begin
        cyc++;
        ks = m_sync[1];
        m_sync = {m_sync[0], key_n};
        exp_vec = 4'b0;
        pre_run = m_run;
        m_run = (ks == exp_level) ? m_run + 1 : 0;
        if (m_run == DB + 1) begin
          m_run = 0;
          exp_level = ~exp_level;
          if (exp_level) begin
            exp_vec = 4'b1000;
            m_hold = 0;
          end else begin
            exp_vec = 4'b0100;
          end
        end else if (exp_level && !ks && pre_run == 0) begin
          m_hold++;
          if (m_hold == LONG) exp_vec = 4'b0010;
          else if (m_hold > LONG && (m_hold - LONG) % REP == 0) exp_vec = 4'b0001;
        end
        if (exp_vec != 4'b0) exp_q.push_back('{cyc: cyc, vec: exp_vec});
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT strobes or one falls due.
  initial begin
    logic [3:0] act;
    ev_t        e;
    forever begin
      @(negedge clk);
      if (done) break;
      act = {key_pulse, key_rel_pulse, key_long, key_rpt};
      if (!rst_n) begin
        checks++;
        if ({act, key_level} !== 5'b0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d got=%b want=00000", cyc, {act, key_level});
        end
      end else begin
        if (act != 4'b0 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe cyc=%0d got=%b want=none", cyc, act);
          end else begin
            e = exp_q.pop_front();
            if (e.vec !== act || e.cyc != cyc) begin
              errors++;
              $display("FAIL strobe cyc=%0d got=%b want=%b at cyc=%0d", cyc, act, e.vec, e.cyc);
            end
          end
        end
        checks++;
        if (key_level !== exp_level) begin
          errors++;
          $display("FAIL level cyc=%0d got=%b want=%b", cyc, key_level, exp_level);
        end
        checks++;
        if ({p2, r2, l2, rpt2, lvl2} !== {exp_vec[3:1], 1'b0, exp_level}) begin
          errors++;
          $display("FAIL norep cyc=%0d got=%b want=%b", cyc, {p2, r2, l2, rpt2, lvl2},
                   {exp_vec[3:1], 1'b0, exp_level});
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_n = v;
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 10);

    // clean presses of random hold length, including past long/repeat points
    for (int i = 0; i < 6; i++) begin
      hold(1'b0, $urandom_range(DB + 3, LONG + 4 * REP + 10));
      hold(1'b1, $urandom_range(DB + 3, 20));
    end
    hold(1'b0, 60);
    hold(1'b1, 15);

    // bounce bursts shorter than the debounce window
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, $urandom_range(1, DB - 1));
      hold(1'b1, $urandom_range(1, 3));
    end
    hold(1'b1, 10);

    // release glitches while held
    hold(1'b0, 15);
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, $urandom_range(1, DB));
      hold(1'b0, $urandom_range(3, 12));
    end
    hold(1'b0, 40);
    hold(1'b1, 15);

    // reset mid-hold, key stays pressed across it
    hold(1'b0, 15);
    pulse_reset(3);
    hold(1'b0, 20);
    hold(1'b1, 15);

    // key held through reset
    key_n = 1'b0;
    pulse_reset(4);
    hold(1'b0, 15);
    hold(1'b1, 15);

    // random run-length traffic
    for (int i = 0; i < 40; i++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 45));
    end
    hold(1'b1, 20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    done = 1'b1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
